modmult_arbiter: RTL

//  Shares one modular_multiplication unit among NUM_REQ requesters (key-gen d search, encrypt, decrypt).

---
 rtl/rsa_pkg.sv | 19 +
 rtl/modmult_arbiter_rr_pick.sv | 30 +++
 rtl/modmult_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modmult arbiter slice.
package rsa_pkg;

  localparam int WIDTH_DEF = 32;

  // Arbiter FSM state encoding, kept as plain constants for compatibility
  // with the older RSA control blocks that compare against raw codes.
  typedef logic [3:0] arb_state_t;

  localparam arb_state_t S_IDLE    = 4'd0;
  localparam arb_state_t S_LATCH   = 4'd1;
  localparam arb_state_t S_MM_RST  = 4'd2;
  localparam arb_state_t S_MM_REL  = 4'd3;
  localparam arb_state_t S_RUN     = 4'd4;
  localparam arb_state_t S_CAPTURE = 4'd5;
  localparam arb_state_t S_RESP    = 4'd6;
  localparam arb_state_t S_HOLD    = 4'd7;

endpackage

// File: rtl/modmult_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping from NUM_REQ-1 back to 0. ptr itself has the lowest priority.
module rr_pick #(
  parameter int NUM_REQ = 3,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  // Scan from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves
    // one unassigned would infer a latch.
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (req[(int'(ptr) + off) % NUM_REQ]) begin
        idx   = IW'((int'(ptr) + off) % NUM_REQ);
        valid = 1'b1;
      end
    end
    if (valid) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/modmult_arbiter.sv
// Shares one modular_multiplication unit among NUM_REQ requesters. Each grant
// latches operands, pulses the modmult reset, holds ready until done and
// captures the result; the requester then keeps grant until it drops req.
module modmult_arbiter
  import rsa_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] base_i,
  input  logic [NUM_REQ*WIDTH-1:0] power_i,
  input  logic [NUM_REQ*WIDTH-1:0] denom_i,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     err,
  output logic [WIDTH-1:0]         result,
  output logic                     mm_reset_n,
  output logic                     mm_ready,
  output logic [WIDTH-1:0]         mm_base,
  output logic [WIDTH-1:0]         mm_power,
  output logic [WIDTH-1:0]         mm_denom,
  input  logic                     mm_done,
  input  logic [WIDTH-1:0]         mm_result
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t         state, state_d;
  logic [IW-1:0]      g;          // current grantee
  logic [IW-1:0]      ptr;        // last granted requester
  logic [CW-1:0]      cnt;        // cycles spent in RUN
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic               req_g;
  logic               abort;
  logic               resp_err;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign req_g = req[g];

  // Next-state logic, including abort on early req drop and the error exits.
  always_comb begin
    state_d  = state;
    abort    = 1'b0;
    resp_err = 1'b0;
    unique case (state)
      S_IDLE:    if (pick_valid) state_d = S_LATCH;
      S_LATCH: begin
        if (mm_denom == '0) begin
          state_d  = S_RESP;
          resp_err = 1'b1;
        end else begin
          state_d = S_MM_RST;
        end
      end
      S_MM_RST:  if (!req_g) abort = 1'b1; else state_d = S_MM_REL;
      S_MM_REL:  if (!req_g) abort = 1'b1; else state_d = S_RUN;
      S_RUN: begin
        if (!req_g) begin
          abort = 1'b1;
        end else if (mm_done) begin
          state_d = S_CAPTURE;
        end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
          state_d  = S_RESP;
          resp_err = 1'b1;
        end
      end
      S_CAPTURE: state_d = S_RESP;
      S_RESP:    state_d = S_HOLD;
      S_HOLD:    if (!req_g) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // State, operand latch and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      g          <= '0;
      ptr        <= IW'(NUM_REQ - 1);
      cnt        <= '0;
      grant      <= '0;
      done       <= '0;
      err        <= 1'b0;
      result     <= '0;
      mm_reset_n <= 1'b0;
      mm_ready   <= 1'b0;
      mm_base    <= '0;
      mm_power   <= '0;
      mm_denom   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state <= state_d;

      // Operands are sampled while grant is still low; later changes are ignored.
      if (state == S_IDLE && pick_valid) begin
        g        <= pick_idx;
        mm_base  <= base_i[int'(pick_idx)*WIDTH +: WIDTH];
        mm_power <= power_i[int'(pick_idx)*WIDTH +: WIDTH];
        mm_denom <= denom_i[int'(pick_idx)*WIDTH +: WIDTH];
      end

      if (state == S_LATCH)   ptr    <= g;
      if (state == S_CAPTURE) result <= mm_result;

      // Counter is zero on RUN entry and counts RUN cycles.
      cnt <= (state == S_RUN) ? cnt + 1'b1 : '0;

      if (state_d == S_IDLE)    grant <= '0;
      else if (state == S_IDLE) grant <= pick_onehot;

      done       <= (state_d == S_RESP) ? grant : '0;
      err        <= resp_err;
      mm_ready   <= (state_d == S_RUN);
      mm_reset_n <= !(state_d == S_MM_RST || abort);
    end
  end

endmodule
